// File: rtl/mv_avg_seq.sv
// mv_avg_seq: sequencer for one external mv_avg datapath.
// Flush, decimate, warm up, then latch the average with a hysteresis flag.
module mv_avg_seq #(
    parameter int DATA_WIDTH   = 16,
    parameter int LOG2_AVG_LEN = 5,
    parameter int DECIM_WIDTH  = 8,
    parameter int FLUSH_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic                   cfg_stop,
    input  logic [DECIM_WIDTH-1:0] cfg_decim,
    input  logic [DATA_WIDTH-1:0]  thresh_hi,
    input  logic [DATA_WIDTH-1:0]  thresh_lo,
    input  logic [DATA_WIDTH-1:0]  sample_in,
    input  logic                   sample_in_valid,
    output logic                   avg_rstn,
    output logic [DATA_WIDTH-1:0]  avg_data_in,
    output logic                   avg_data_in_valid,
    input  logic [DATA_WIDTH-1:0]  avg_data_out,
    input  logic                   avg_data_out_valid,
    output logic [DATA_WIDTH-1:0]  avg_value,
    output logic                   avg_settled,
    output logic                   above_thresh,
    output logic [1:0]             state
);

    localparam int FCW = $clog2(FLUSH_CYCLES + 1);
    localparam int WCW = LOG2_AVG_LEN + 1;
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);
    localparam logic [WCW-1:0] WCNT_LAST  = WCW'((1 << LOG2_AVG_LEN) - 1);
    localparam logic [WCW-1:0] WCNT_FULL  = WCW'(1 << LOG2_AVG_LEN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLUSH  = 2'd1,
        S_WARMUP = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t cur, nxt;

    logic [FCW-1:0]         fcnt;
    logic [WCW-1:0]         wcnt;
    logic [DECIM_WIDTH-1:0] dcnt;
    logic [DECIM_WIDTH-1:0] decim_lat;
    logic                   upd_d;

    logic restart;
    logic flush_done;
    logic warm_done;
    logic active;
    logic fwd_ok;

    assign state      = cur;
    assign restart    = cfg_start && !cfg_stop;
    assign flush_done = (cur == S_FLUSH) && (fcnt == FLUSH_LAST);
    assign warm_done  = (cur == S_WARMUP) && avg_data_out_valid
                        && (wcnt == WCNT_LAST);
    assign active     = (cur == S_WARMUP) || (cur == S_RUN);
    assign fwd_ok     = active && ((nxt == S_WARMUP) || (nxt == S_RUN));

    // Next-state decode: stop beats start, start restarts from any state.
    always_comb begin
        nxt = cur;
        if (cfg_stop) begin
            nxt = S_IDLE;
        end else if (cfg_start) begin
            nxt = S_FLUSH;
        end else begin
            unique case (1'b1)
                flush_done: nxt = S_WARMUP;
                warm_done:  nxt = S_RUN;
                default:    nxt = cur;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) cur <= S_IDLE;
        else     cur <= nxt;
    end

    // Flush timer and decimation ratio captured at (re)start.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt      <= '0;
            decim_lat <= '0;
        end else if (restart) begin
            fcnt      <= '0;
            decim_lat <= cfg_decim;
        end else if (cur == S_FLUSH) begin
            fcnt <= flush_done ? '0 : fcnt + 1'b1;
        end
    end

    // Datapath reset follows the state it is entering.
    always_ff @(posedge clk) begin
        if (rst) avg_rstn <= 1'b0;
        else     avg_rstn <= (nxt == S_WARMUP) || (nxt == S_RUN);
    end

    // Decimator: forward one of every decim_lat+1 strobes, registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            dcnt              <= '0;
            avg_data_in       <= '0;
            avg_data_in_valid <= 1'b0;
        end else begin
            avg_data_in_valid <= 1'b0;
            if (restart) begin
                dcnt <= '0;
            end else if (fwd_ok && sample_in_valid) begin
                if (dcnt == decim_lat) begin
                    dcnt              <= '0;
                    avg_data_in       <= sample_in;
                    avg_data_in_valid <= 1'b1;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end
        end
    end

    // Warm-up counting, average capture and settle flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt        <= '0;
            avg_value   <= '0;
            avg_settled <= 1'b0;
            upd_d       <= 1'b0;
        end else if (restart) begin
            wcnt        <= '0;
            avg_value   <= '0;
            avg_settled <= 1'b0;
            upd_d       <= 1'b0;
        end else begin
            upd_d <= 1'b0;
            if (active && avg_data_out_valid) begin
                avg_value <= avg_data_out;
                upd_d     <= 1'b1;
            end
            if ((cur == S_WARMUP) && avg_data_out_valid
                && (wcnt != WCNT_FULL)) begin
                wcnt <= wcnt + 1'b1;
            end
            if (warm_done && (nxt == S_RUN)) begin
                avg_settled <= 1'b1;
            end
        end
    end

    // Hysteresis compare on the freshly latched average.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            above_thresh <= 1'b0;
        end else if ((cur == S_RUN) && upd_d) begin
            if ($signed(avg_value) > $signed(thresh_hi)) begin
                above_thresh <= 1'b1;
            end else if ($signed(avg_value) < $signed(thresh_lo)) begin
                above_thresh <= 1'b0;
            end
        end
    end

endmodule
